// File: rtl/rv32_writeback_scoreboard_if.sv
// Writeback scoreboard bus bundle.
// Groups the issue / complete handshakes, the decode-stage source query and
// the scoreboard status outputs.
//   master : the pipeline side (exec issue, long-latency unit complete, decode query)
//   slave  : the scoreboard itself
// query_rs[i] is source i (0 = rs1, 1 = rs2, 2 = rs3), gated by use_rs[i].
interface rv32_writeback_scoreboard_if;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic            complete_valid;
  logic [4:0]      complete_rd;
  logic [2:0][4:0] query_rs;
  logic [2:0]      use_rs;
  logic            stall;
  logic [31:0]     busy_vec;
  logic [2:0]      outstanding;
  logic            error;

  modport master (
    output issue_valid, issue_rd, complete_valid, complete_rd, query_rs, use_rs,
    input  issue_ready, stall, busy_vec, outstanding, error
  );

  modport slave (
    input  issue_valid, issue_rd, complete_valid, complete_rd, query_rs, use_rs,
    output issue_ready, stall, busy_vec, outstanding, error
  );
endinterface

// File: rtl/rv32_writeback_scoreboard.sv
// RV32 writeback scoreboard for long-latency register writes (loads, divides).
// Tracks up to three pending writes per register x1..x31 with a 2-bit counter
// and a total in-flight count bounded by MAX_OUTSTANDING (1..7).
// Ports:
//   clk     : clock, all state updates on the rising edge
//   resetn  : asynchronous active-low reset, clears all pending state at once
//   sb      : slave side of rv32_writeback_scoreboard_if
//             issue_valid/issue_rd/issue_ready : long-latency issue handshake
//             complete_valid/complete_rd       : writeback of a pending register
//             query_rs/use_rs -> stall         : decode hazard check (combinational)
//             busy_vec, outstanding, error     : status (error is sticky)
// x0 is never tracked: issues and completes to x0 change nothing.
module rv32_writeback_scoreboard #(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                        clk,
  input logic                        resetn,
  rv32_writeback_scoreboard_if.slave sb
);

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  logic [1:0]  cnt [32];
  logic [2:0]  outstanding_r;
  logic        error_r;

  logic [1:0]  issue_cnt;
  logic [1:0]  cmp_cnt;
  logic        issue_hit;
  logic        ready;
  logic        issue_acc;
  logic        issue_bad;
  logic        cmp_hit;
  logic        cmp_ok;
  logic        cmp_bad;
  logic        stall_c;
  logic [31:0] busy_c;

  // A source blocks if its register still has a write pending after this
  // cycle's writeback, or if the instruction leaving exec now targets it.
  function automatic logic blocked(input logic       use_src,
                                   input logic [4:0] rs,
                                   input logic [1:0] rs_cnt,
                                   input logic       cv,
                                   input logic [4:0] crd,
                                   input logic       iv,
                                   input logic [4:0] ird);
    logic hit;
    hit = (rs_cnt > 2'd1) ||
          ((rs_cnt == 2'd1) && !(cv && (crd == rs))) ||
          (iv && (ird == rs));
    return use_src && (rs != 5'd0) && hit;
  endfunction

  assign issue_cnt = cnt[sb.issue_rd];
  assign cmp_cnt   = cnt[sb.complete_rd];
  assign issue_hit = (sb.issue_rd != 5'd0);
  assign ready     = (outstanding_r < MAX_OUT) && (!issue_hit || (issue_cnt != 2'd3));
  assign issue_acc = sb.issue_valid && ready && issue_hit;
  assign issue_bad = sb.issue_valid && !ready;
  assign cmp_hit   = sb.complete_valid && (sb.complete_rd != 5'd0);
  assign cmp_ok    = cmp_hit && (cmp_cnt != 2'd0);
  assign cmp_bad   = cmp_hit && (cmp_cnt == 2'd0);

  always_comb begin
    stall_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (blocked(sb.use_rs[i], sb.query_rs[i], cnt[sb.query_rs[i]],
                  sb.complete_valid, sb.complete_rd, sb.issue_valid, sb.issue_rd))
        stall_c = 1'b1;
    end
  end

  always_comb begin
    busy_c = '0;
    for (int n = 1; n < 32; n++) busy_c[n] = (cnt[n] != 2'd0);
  end

  // State update: per-register counters, total, sticky error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 32; n++) cnt[n] <= '0;
      outstanding_r <= '0;
      error_r       <= 1'b0;
    end else begin
      // cnt[0] is never updated, so it stays at its reset value of 0.
      for (int n = 1; n < 32; n++) begin
        if (issue_acc && (sb.issue_rd == 5'(n)) && !(cmp_ok && (sb.complete_rd == 5'(n))))
          cnt[n] <= cnt[n] + 2'd1;
        else if (cmp_ok && (sb.complete_rd == 5'(n)) && !(issue_acc && (sb.issue_rd == 5'(n))))
          cnt[n] <= cnt[n] - 2'd1;
      end
      if (issue_acc && !cmp_ok)
        outstanding_r <= outstanding_r + 3'd1;
      else if (cmp_ok && !issue_acc)
        outstanding_r <= outstanding_r - 3'd1;
      if (issue_bad || cmp_bad)
        error_r <= 1'b1;
    end
  end

  assign sb.issue_ready = ready;
  assign sb.stall       = stall_c;
  assign sb.busy_vec    = busy_c;
  assign sb.outstanding = outstanding_r;
  assign sb.error       = error_r;

endmodule

// File: tb/tb_rv32_writeback_scoreboard.sv
module tb_rv32_writeback_scoreboard;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  rv32_writeback_scoreboard_if bus ();

  rv32_writeback_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] busy;
    logic [2:0]  outst;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   mcnt [32];
  int   mout;
  bit   merr;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 32; n++) mcnt[n] = 0;
    mout = 0;
    merr = 1'b0;
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int n = 1; n < 32; n++) b[n] = (mcnt[n] != 0);
    return b;
  endfunction

  function automatic bit model_ready(input logic [4:0] ird);
    return (mout < MAXO) && ((ird == 5'd0) || (mcnt[ird] < 3));
  endfunction

  function automatic bit model_stall(input logic [2:0] use_v,
                                     input logic [4:0] q0, input logic [4:0] q1,
                                     input logic [4:0] q2, input bit cv,
                                     input logic [4:0] crd, input bit iv,
                                     input logic [4:0] ird);
    logic [4:0] q [3];
    bit s;
    q[0] = q0; q[1] = q1; q[2] = q2;
    s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (use_v[i] && q[i] != 5'd0) begin
        if (mcnt[q[i]] > 1) s = 1'b1;
        if (mcnt[q[i]] == 1 && !(cv && crd == q[i])) s = 1'b1;
        if (iv && ird == q[i]) s = 1'b1;
      end
    end
    return s;
  endfunction

  task automatic drive_idle();
    bus.issue_valid    = 1'b0;
    bus.issue_rd       = '0;
    bus.complete_valid = 1'b0;
    bus.complete_rd    = '0;
    bus.query_rs       = '0;
    bus.use_rs         = '0;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input string tag, input bit iv, input logic [4:0] ird,
                      input bit cv, input logic [4:0] crd,
                      input logic [4:0] q0, input logic [4:0] q1, input logic [4:0] q2,
                      input logic [2:0] use_v);
    bit   rdy, acc, cok, cbad;
    exp_t e;
    bus.issue_valid    = iv;
    bus.issue_rd       = ird;
    bus.complete_valid = cv;
    bus.complete_rd    = crd;
    bus.query_rs[0]    = q0;
    bus.query_rs[1]    = q1;
    bus.query_rs[2]    = q2;
    bus.use_rs         = use_v;
    rdy = model_ready(ird);
    @(negedge clk);
    chk({tag, "_stall"}, 32'(bus.stall), 32'(model_stall(use_v, q0, q1, q2, cv, crd, iv, ird)));
    chk({tag, "_ready"}, 32'(bus.issue_ready), 32'(rdy));
    acc  = iv && rdy && (ird != 5'd0);
    cok  = cv && (crd != 5'd0) && (mcnt[crd] != 0);
    cbad = cv && (crd != 5'd0) && (mcnt[crd] == 0);
    if (acc) begin mcnt[ird]++; mout++; end
    if (cok) begin mcnt[crd]--; mout--; end
    if ((iv && !rdy) || cbad) merr = 1'b1;
    e.busy  = model_busy();
    e.outst = 3'(mout);
    e.err   = merr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_busy"},  bus.busy_vec, e.busy);
    chk({tag, "_outst"}, 32'(bus.outstanding), 32'(e.outst));
    chk({tag, "_err"},   32'(bus.error), 32'(e.err));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
  endtask

  initial begin
    drive_idle();
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outst", 32'(bus.outstanding), 32'd0);
    chk("rst_busy",  bus.busy_vec, 32'd0);
    chk("rst_err",   32'(bus.error), 32'd0);
    chk("rst_ready", 32'(bus.issue_ready), 32'd1);
    resetn = 1'b1;

    // Issue rd=5, query, complete with same-cycle stall release
    step("i5",  1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    chk("i5_busy5", 32'(bus.busy_vec[5]), 32'd1);
    step("q5",  1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 3'b001);
    step("c5",  1'b0, 5'd0, 1'b1, 5'd5, 5'd5, 5'd0, 5'd0, 3'b001);
    chk("c5_busy5", 32'(bus.busy_vec[5]), 32'd0);

    // Per-register limit of 3 on x7
    for (int k = 0; k < 3; k++) step("i7", 1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    step("rdy7", 1'b0, 5'd7, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    step("rdy8", 1'b0, 5'd8, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    step("c7a", 1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd7, 5'd0, 3'b010);
    step("q7",  1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 3'b100);
    chk("q7_stall_const", 32'(bus.stall), 32'd1);
    step("c7b", 1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000);
    step("c7c", 1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000);

    // Same-cycle issue and complete on x9, then different registers
    step("i9",   1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    step("ic9",  1'b1, 5'd9, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0, 3'b001);
    chk("ic9_outst_const", 32'(bus.outstanding), 32'd1);
    step("i11c9", 1'b1, 5'd11, 1'b1, 5'd9, 5'd11, 5'd9, 5'd0, 3'b011);
    step("c11",  1'b0, 5'd0, 1'b1, 5'd11, 5'd0, 5'd0, 5'd0, 3'b000);

    // Total limit: four issues fill MAXO, fifth flags error
    for (int k = 1; k <= 4; k++) step("ifill", 1'b1, 5'(k), 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    chk("fill_outst_const", 32'(bus.outstanding), 32'd4);
    step("rdy6",  1'b0, 5'd6, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    step("over6", 1'b1, 5'd6, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    chk("over6_err_const", 32'(bus.error), 32'd1);
    step("c4",    1'b0, 5'd0, 1'b1, 5'd4, 5'd0, 5'd0, 5'd0, 3'b000);

    // Asynchronous reset with 3 writes pending, asserted between edges
    drive_idle();
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("arst_outst", 32'(bus.outstanding), 32'd0);
    chk("arst_busy",  bus.busy_vec, 32'd0);
    chk("arst_err",   32'(bus.error), 32'd0);
    chk("arst_ready", 32'(bus.issue_ready), 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step("post_rst_i10", 1'b1, 5'd10, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    chk("post_rst_outst_const", 32'(bus.outstanding), 32'd1);
    step("c10", 1'b0, 5'd0, 1'b1, 5'd10, 5'd0, 5'd0, 5'd0, 3'b000);

    // Complete to an idle register, sticky error, x0 ignored
    step("c3bad", 1'b0, 5'd0, 1'b1, 5'd3, 5'd0, 5'd0, 5'd0, 3'b000);
    for (int k = 0; k < 10; k++) idle("hold");
    chk("hold_err_const", 32'(bus.error), 32'd1);
    step("i0", 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    step("q0", 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b111);
    chk("x0_busy_const", bus.busy_vec, 32'd0);

    // Mixed traffic on a few registers to exercise hazards and limits
    for (int k = 0; k < 60; k++) begin
      step("mix", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_writeback_scoreboard.md
RV32_WRITEBACK_SCOREBOARD -- requirements
Module: rv32_writeback_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the total long-latency register writes in flight (range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port issue_valid, input, 1, meaning a long-latency instruction (load, div) leaves exec this cycle.
REQ-005 SHALL have port issue_rd, input, rv_reg_id_t (5), the destination register of the issued instruction.
REQ-006 SHALL have port issue_ready, output, 1, meaning the scoreboard accepts an issue this cycle.
REQ-007 SHALL have port complete_valid, input, 1, meaning the long-latency unit writes back this cycle.
REQ-008 SHALL have port complete_rd, input, rv_reg_id_t (5), the register written back.
REQ-009 SHALL have port query_rs, input, rv_reg_id_t [3], the decode-stage source registers (rs1, rs2, rs3).
REQ-010 SHALL have port use_rs, input, logic [3], the per-source use flags.
REQ-011 SHALL have port stall, output, 1, meaning decode must hold.
REQ-012 SHALL have port busy_vec, output, 32, where bit n is set while register n has a write pending.
REQ-013 SHALL have port outstanding, output, 3, the total number of pending writes.
REQ-014 SHALL have port error, output, 1, a sticky protocol-violation flag.

Function
REQ-015 SHALL keep a 2-bit pending counter per register for x1..x31; x0 SHALL never be tracked (its count stays 0, and issues or completes to x0 are ignored).
REQ-016 issue_ready SHALL be 1 iff outstanding < MAX_OUTSTANDING and the counter of issue_rd is < 3; for issue_rd = x0, only the total limit SHALL apply.
REQ-017 An accepted issue (issue_valid & issue_ready, rd != 0) SHALL increment count[rd] and outstanding on the next edge.
REQ-018 issue_valid with issue_ready = 0 SHALL change no state and SHALL set error.
REQ-019 A complete (complete_valid, rd != 0) SHALL decrement count[rd] and outstanding on the next edge.
REQ-020 A complete to a register whose count is 0 SHALL change no counter and SHALL set error.
REQ-021 Same-cycle accepted issue and complete to the same rd SHALL leave count[rd] and outstanding unchanged.
REQ-022 Same-cycle issue and complete to different registers SHALL update both counters; outstanding SHALL stay unchanged.
REQ-023 busy_vec[n] SHALL equal (count[n] != 0), registered; busy_vec[0] SHALL be 0.
REQ-024 For each idx with use_rs[idx] = 1 and query_rs[idx] != 0, source idx SHALL be "blocked" if any of the following holds:
  - count[rs] > 1;
  - count[rs] == 1 and not (complete_valid & complete_rd == rs);
  - issue_valid & issue_rd == rs.
REQ-025 stall SHALL be the combinational OR of the blocked flags, with zero-cycle latency from its inputs.
REQ-026 error, once set, SHALL remain 1 until reset.
REQ-027 The outstanding counter SHALL never wrap; REQ-016 and REQ-018 guarantee the range 0..MAX_OUTSTANDING.

Reset
REQ-028 While resetn = 0, the block SHALL hold all counters at 0, outstanding = 0, busy_vec = 0, error = 0 and issue_ready = 1; stall SHALL follow REQ-024 with all counts at 0.
REQ-029 Reset asserted mid-operation SHALL clear all pending state immediately, without waiting for a clock edge.
REQ-030 After resetn rises, the first edge SHALL accept an issue normally.

Verification
REQ-031 Issue rd=5, then query rs1=5 with use_rs[0]=1 -> stall=1 and busy_vec[5]=1; complete rd=5 -> stall=0 in that same cycle, busy_vec[5]=0 after the edge.
REQ-032 Issue 4 times to x1..x4 -> outstanding=4 and issue_ready=0; a fifth issue to x6 -> error=1 and outstanding stays 4.
REQ-033 Issue rd=7 three times -> issue_ready=0 for rd=7 and 1 for rd=8 (with MAX_OUTSTANDING=7); one complete rd=7 -> stall still 1 for rs=7.
REQ-034 Same-cycle issue and complete of rd=9 with count 1 -> count stays 1 and outstanding is unchanged.
REQ-035 Complete rd=3 with count 0 -> error=1, held across 10 cycles; issue rd=0 -> busy_vec stays 0 and stall=0 for rs=0.
REQ-036 Assert resetn=0 with 3 writes pending between edges -> outstanding=0, busy_vec=0 and error=0 asynchronously.
